lut_neuron_bank_pipe: RTL
=========================

// Module: lut_neuron_bank_pipe
// PURPOSE
//  Parametrised, pipelined bank of N_NEURONS LUT neurons with run-time programmable truth tables.
//  - Each neuron maps an IN_WIDTH-bit input slice to an OUT_WIDTH-bit output.
//  - Succeeds the fixed-ROM per-neuron combinational modules: tables are loaded over a config port.
//  - Adds a valid/ready stream interface with backpressure.
//  - Sits between quantised feature/activation layers in the classifier datapath.
// PARAMETERS
//  N_NEURONS  4  neurons in the bank; NIDX_W = max(1,$clog2(N_NEURONS))
//  IN_WIDTH   6  input bits per neuron (fan-in * bits per input); table depth = 2**IN_WIDTH
//  OUT_WIDTH  2  output bits per neuron
// PORTS
//  clk         in   1                     clock, all logic rising-edge
//  rst         in   1                     asynchronous, active-high reset
//  cfg_we      in   1                     table write strobe
//  cfg_neuron  in   NIDX_W                target neuron index
//  cfg_addr    in   IN_WIDTH              table entry address
//  cfg_data    in   OUT_WIDTH             table entry value
//  cfg_err     out  1                     sticky: write issued to neuron index >= N_NEURONS
//  prog_mask   out  N_NEURONS             bit n set once neuron n has received any write
//  in_valid    in   1                     input beat valid
//  in_ready    out  1                     bank can accept a beat
//  in_data     in   N_NEURONS*IN_WIDTH    neuron n input = in_data[n*IN_WIDTH +: IN_WIDTH]
//  out_valid   out  1                     output beat valid
//  out_ready   in   1                     downstream accepts
//  out_data    out  N_NEURONS*OUT_WIDTH   neuron n output = out_data[n*OUT_WIDTH +: OUT_WIDTH]
// BEHAVIOUR
//  Reset values:
//  - v1, v2 (stage valids), out_valid, out_data, cfg_err and prog_mask all go to 0 immediately.
//  - Table contents are not reset.
//  Pipeline (2 stages; latency 2 cycles, in-beat accept to out_valid when unstalled):
//  - S1 registers in_data on accept (in_valid & in_ready).
//  - S2 registers the LUT read of the S1 addresses into out_data.
//  - Unprogrammed neuron (prog_mask[n]=0): its out_data field is forced to 0, not a table read.
//  Handshake:
//  - stall = out_valid & ~out_ready; in_ready = ~stall.
//  - On stall both stages hold data and valid; no bubble is inserted and no beat is lost or duplicated.
//  - in_ready does not depend combinationally on in_valid.
//  - Throughput is 1 beat/cycle when out_ready stays high.
//  - out_data is stable while out_valid & ~out_ready.
//  Config:
//  - cfg_we writes table[cfg_neuron][cfg_addr] = cfg_data at the clock edge and sets prog_mask[cfg_neuron].
//  - Writes are accepted at any time, including mid-stream and during stall.
//  - Read-during-write to the same entry: the S2 read in that cycle returns the OLD value; the next read returns the new value.
//  - A stalled beat held in S2 does not re-read its table, so its out_data stays unchanged.
//  - cfg_neuron >= N_NEURONS (non-power-of-2 N only): the write is dropped, cfg_err is set, and it stays set until reset.
//  Reset mid-operation: in-flight beats are discarded; prog_mask clears, so all outputs read 0 until tables are reprogrammed.
//  Width rules: no arithmetic; cfg_addr and in_data slices index tables directly (no truncation).
// STRUCTURE
//  - Package lut_bank_pkg: function clog2_min1, and localparam TABLE_DEPTH = 2**IN_WIDTH as a derived helper function.
//  - Sub-module lut_neuron_ram: one neuron table as distributed RAM.
//    - 1 write port; 1 async read whose registered output is held in the top level under ~stall.
//    - Instantiated N_NEURONS times via generate.
//  - Top level holds the stage valids, stall logic, prog_mask and cfg_err.
// TESTING
//  1 Reset: assert rst mid-cycle -> out_valid=0, out_data=0, prog_mask=0, cfg_err=0 without a clock edge.
//  2 Program all 4 neurons with table[n][a]=(a+n)%4, stream addrs 0..63 with out_ready=1
//    -> out_data matches the model, first beat 2 cycles after accept, 64 beats in 65 cycles after the first accept.
//  3 Backpressure: out_ready toggles randomly over 200 beats -> no loss/dup, order kept, in_ready low exactly when out_valid & ~out_ready.
//  4 Unprogrammed: program only neuron 0 -> out_data fields 1..3 = 2'b00; prog_mask=4'b0001.
//  5 Read-during-write: beat with addr 6'h2A in S1 while writing 2'b11 to neuron 2 entry 6'h2A (old 2'b01)
//    -> that beat gives 01, the next identical beat gives 11.
//  6 Bad index (N_NEURONS=3): write cfg_neuron=3 -> cfg_err=1 and sticky, no table changed, prog_mask unchanged.

Source files
------------

// File: rtl/lut_bank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut_bank_pkg : sizing helpers shared by the LUT neuron bank.  Rev 1.0
// ---------------------------------------------------------------------------
package lut_bank_pkg;

  // Index fields never shrink to zero bits, even for a single-neuron bank.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int table_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_neuron_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut_neuron_ram : one neuron truth table, 1 sync write / 1 async read.  Rev 1.0
// ---------------------------------------------------------------------------
module lut_neuron_ram
  import lut_bank_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int TABLE_DEPTH = table_depth(ADDR_W);

  logic [DATA_W-1:0] mem [TABLE_DEPTH];

  // Contents are deliberately not reset so this maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/lut_neuron_bank_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lut_neuron_bank_pipe : 2-stage valid/ready bank of programmable LUT neurons.
// Rev 1.0
// ---------------------------------------------------------------------------
module lut_neuron_bank_pipe
  import lut_bank_pkg::*;
#(
  parameter int  N_NEURONS = 4,
  parameter int  IN_WIDTH  = 6,
  parameter int  OUT_WIDTH = 2,
  localparam int NIDX_W    = clog2_min1(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [NIDX_W-1:0]             cfg_neuron,
  input  logic [IN_WIDTH-1:0]           cfg_addr,
  input  logic [OUT_WIDTH-1:0]          cfg_data,
  output logic                          cfg_err,
  output logic [N_NEURONS-1:0]          prog_mask,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_WIDTH-1:0] out_data
);

  logic                           stall;
  logic                           v1;
  logic                           v2;
  logic [N_NEURONS*IN_WIDTH-1:0]  s1_data;
  logic [N_NEURONS-1:0]           sel;
  logic [N_NEURONS*OUT_WIDTH-1:0] lut_word;

  assign stall     = v2 & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v2;

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    localparam logic [NIDX_W-1:0] IDX = NIDX_W'(n);
    logic [OUT_WIDTH-1:0] rd;

    assign sel[n] = cfg_we & (cfg_neuron == IDX);

    lut_neuron_ram #(
      .ADDR_W (IN_WIDTH),
      .DATA_W (OUT_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (sel[n]),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (s1_data[n*IN_WIDTH +: IN_WIDTH]),
      .rdata (rd)
    );

    // A never-written table holds garbage, so its field is forced to zero.
    assign lut_word[n*OUT_WIDTH +: OUT_WIDTH] = prog_mask[n] ? rd : '0;
  end

  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      s1_data <= in_data;
    end
  end

  // Both stages freeze together on stall, so the S2 word is never re-read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      out_data <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      if (v1) begin
        out_data <= lut_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_mask <= '0;
      cfg_err   <= 1'b0;
    end else if (cfg_we) begin
      prog_mask <= prog_mask | sel;
      if (sel == '0) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
